// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexes one shared hex decoder across NUM_DIGITS common-anode digits,
// with a per-digit register file and a blank gap at the start of every slot to prevent ghosting.
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50_000,
    parameter int BLANK_CYCLES = 500,
    localparam int AW = $clog2(NUM_DIGITS)
) (
    input  logic                  clk_in,
    input  logic                  nReset,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  wr_blank,
    output logic [3:0]            hex_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] an,
    output logic [AW-1:0]         digit_sel,
    output logic                  frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;
    localparam logic [NUM_DIGITS-1:0] ALL_OFF = '1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [AW-1:0] LAST_DIGIT = AW'(NUM_DIGITS - 1);

    logic [3:0]    val [NUM_DIGITS];
    logic          dp  [NUM_DIGITS];
    logic          blk [NUM_DIGITS];
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          blank_latched;
    logic [AW-1:0] next_sel;

    assign next_sel = (digit_sel == LAST_DIGIT) ? '0 : digit_sel + 1'b1;

    always_ff @(posedge clk_in) begin
        if (!nReset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                val[i] <= '0;
                dp[i]  <= 1'b0;
                blk[i] <= 1'b0;
            end
            state         <= IDLE;
            cnt           <= '0;
            an            <= ALL_OFF;
            hex_out       <= '0;
            dp_out        <= 1'b0;
            blank_latched <= 1'b0;
            digit_sel     <= '0;
            frame_tick    <= 1'b0;
        end else begin
            // register file reads below see pre-write contents, giving read-before-write
            if (wr_en && 32'(wr_addr) < NUM_DIGITS) begin
                val[wr_addr] <= wr_data;
                dp[wr_addr]  <= wr_dp;
                blk[wr_addr] <= wr_blank;
            end
            frame_tick <= 1'b0;
            case (state)
                IDLE: begin
                    an  <= ALL_OFF;
                    cnt <= '0;
                    if (enable) begin
                        state         <= BLANK;
                        hex_out       <= val[digit_sel];
                        dp_out        <= dp[digit_sel];
                        blank_latched <= blk[digit_sel];
                    end
                end
                BLANK: begin
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= '0;
                        an    <= ALL_OFF;
                    end else if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        cnt   <= '0;
                        an    <= blank_latched ? ALL_OFF : ~(NUM_DIGITS'(1) << digit_sel);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= '0;
                        an    <= ALL_OFF;
                    end else if (cnt == SHOW_LAST) begin
                        state         <= BLANK;
                        cnt           <= '0;
                        an            <= ALL_OFF;
                        digit_sel     <= next_sel;
                        frame_tick    <= (digit_sel == LAST_DIGIT);
                        hex_out       <= val[next_sel];
                        dp_out        <= dp[next_sel];
                        blank_latched <= blk[next_sel];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    an    <= ALL_OFF;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: directed and random stimulus checked against a slot-arithmetic model
// that derives digit and phase from cycles elapsed since the scan (re)started.
module tb_seg_scan_controller;
    localparam int ND = 4;
    localparam int RD = 10;
    localparam int BC = 2;

    logic       clk_in = 1'b0;
    logic       nReset = 1'b0;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_dp = 1'b0;
    logic       wr_blank = 1'b0;
    logic [3:0] hex_out;
    logic       dp_out;
    logic [3:0] an;
    logic [1:0] digit_sel;
    logic       frame_tick;

    seg_scan_controller #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk_in(clk_in), .nReset(nReset), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank),
        .hex_out(hex_out), .dp_out(dp_out), .an(an), .digit_sel(digit_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk_in = ~clk_in;

    int   m_val [ND];
    int   m_dp  [ND];
    int   m_bl  [ND];
    bit   run;
    int   e;
    int   sdig;
    int   m_hex;
    int   m_dpo;
    int   m_bll;
    int   m_ft;
    int   passed = 0;
    int   total = 0;

    function automatic int cur();
        return (sdig + e / RD) % ND;
    endfunction

    task automatic latch(input int d);
        m_hex = m_val[d];
        m_dpo = m_dp[d];
        m_bll = m_bl[d];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    endtask

    task automatic tick();
        int c;
        logic [3:0] exp_an;
        @(posedge clk_in);
        if (!nReset) begin
            for (int i = 0; i < ND; i++) begin
                m_val[i] = 0;
                m_dp[i]  = 0;
                m_bl[i]  = 0;
            end
            run = 0; e = 0; sdig = 0;
            m_hex = 0; m_dpo = 0; m_bll = 0; m_ft = 0;
        end else begin
            m_ft = 0;
            if (!run) begin
                if (enable) begin
                    run = 1;
                    e = 0;
                    latch(sdig);
                end
            end else if (!enable) begin
                sdig = cur();
                run = 0;
                e = 0;
            end else begin
                e++;
                if (e % RD == 0) begin
                    latch(cur());
                    m_ft = (cur() == 0);
                end
            end
            if (wr_en && int'(wr_addr) < ND) begin
                m_val[wr_addr] = int'(wr_data);
                m_dp[wr_addr]  = int'(wr_dp);
                m_bl[wr_addr]  = int'(wr_blank);
            end
        end
        #1;
        c = run ? cur() : sdig;
        exp_an = (!run || e % RD < BC || m_bll != 0) ? 4'hF : ~(4'b0001 << c);
        chk("an", 32'(an), 32'(exp_an));
        chk("hex_out", 32'(hex_out), 32'(m_hex));
        chk("dp_out", 32'(dp_out), 32'(m_dpo));
        chk("digit_sel", 32'(digit_sel), 32'(c));
        chk("frame_tick", 32'(frame_tick), 32'(m_ft));
    endtask

    task automatic wr(input int a, input int d, input int p, input int b);
        wr_en = 1'b1;
        wr_addr = 2'(a);
        wr_data = 4'(d);
        wr_dp = 1'(p);
        wr_blank = 1'(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic run_until(input int dig, input int ph);
        int n = 0;
        while (!(run && cur() == dig && e % RD == ph) && n < 200) begin
            tick();
            n++;
        end
        total++;
        assert (n < 200) passed++;
        else $error("FAIL wait_slot: observed timeout expected digit %0d phase %0d", dig, ph);
    endtask

    initial begin
        // reset held 3 cycles
        nReset = 1'b0;
        repeat (3) tick();
        nReset = 1'b1;
        wr(0, 4'h1, 0, 0);
        wr(1, 4'h2, 1, 0);
        wr(2, 4'hA, 0, 0);
        wr(3, 4'hF, 1, 0);
        enable = 1'b1;
        repeat (45) tick();
        // overwrite digit 1 while it is lit
        run_until(1, 4);
        wr(1, 4'h7, 0, 0);
        repeat (50) tick();
        // suppress digit 2, then pause mid-SHOW and resume
        wr(2, 4'h5, 1, 1);
        run_until(2, 4);
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        repeat (12) tick();
        wr(2, 4'h6, 0, 0);
        run_until(2, 5);
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (12) tick();
        // reset pulse mid-frame
        run_until(3, 5);
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        repeat (15) tick();
        repeat (800) begin
            wr_en = ($urandom % 4 == 0);
            wr_addr = 2'($urandom);
            wr_data = 4'($urandom);
            wr_dp = 1'($urandom);
            wr_blank = ($urandom % 4 == 0);
            enable = ($urandom % 40 != 0);
            nReset = ($urandom % 300 != 0);
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
